// File: rtl/spi_reg_ctrl.sv
// Register-bus sequencer behind an SPI slave byte interface: command byte selects
// read/write and start address, following bytes burst at auto-incrementing addresses.
module spi_reg_ctrl #(
    parameter int         ADDR_W      = 7,
    parameter int         RD_TIMEOUT  = 8,
    parameter logic [7:0] RD_ERR_BYTE = 8'hEE
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_spi_cs_b,
    input  logic              i_rx_data_valid,
    input  logic [7:0]        i_rx_byte,
    output logic              o_tx_data_valid,
    output logic [7:0]        o_tx_byte,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic              o_reg_wr_en,
    output logic [7:0]        o_reg_wr_data,
    output logic              o_reg_rd_en,
    input  logic [7:0]        i_reg_rd_data,
    input  logic              i_reg_rd_ack,
    input  logic              i_err_clr,
    output logic              o_busy,
    output logic              o_err_timeout
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_NEXT = 3'd4;
    localparam logic [2:0] S_WR_DATA = 3'd5;
    localparam int         CNT_W     = $clog2(RD_TIMEOUT + 1);

    logic              r_cs_meta, r_cs_sync, r_cs_act_d;
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic [7:0]        r_tx_byte;
    logic              r_tx_vld;
    logic              r_wr_en;
    logic [7:0]        r_wr_data;
    logic              r_err;

    logic w_cs_act, w_cs_rise, w_ack, w_timeout;

    assign w_cs_act  = ~r_cs_sync;
    assign w_cs_rise = w_cs_act & ~r_cs_act_d;
    assign w_ack     = (r_state == S_RD_WAIT) & w_cs_act & i_reg_rd_ack;
    assign w_timeout = (r_state == S_RD_WAIT) & w_cs_act & ~i_reg_rd_ack
                     & (r_tmo_cnt == CNT_W'(RD_TIMEOUT - 1));

    // Sync flops and the previous-CS register reset to "active" so a frame
    // already running at reset is ignored until CS is released.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_cs_meta  <= 1'b0;
            r_cs_sync  <= 1'b0;
            r_cs_act_d <= 1'b1;
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_tmo_cnt  <= '0;
            r_tx_byte  <= 8'h00;
            r_tx_vld   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_cs_meta  <= i_spi_cs_b;
            r_cs_sync  <= r_cs_meta;
            r_cs_act_d <= w_cs_act;
            r_tx_vld   <= 1'b0;
            r_wr_en    <= 1'b0;

            if (r_wr_en)
                r_addr <= r_addr + ADDR_W'(1);

            if (w_timeout)
                r_err <= 1'b1;
            else if (i_err_clr)
                r_err <= 1'b0;

            if (!w_cs_act) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_rise) begin
                            r_state   <= S_CMD;
                            r_tx_byte <= 8'h00;
                        end
                    end
                    S_CMD: begin
                        if (i_rx_data_valid) begin
                            r_addr  <= i_rx_byte[ADDR_W-1:0];
                            r_state <= i_rx_byte[7] ? S_RD_REQ : S_WR_DATA;
                        end
                    end
                    S_RD_REQ: begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        if (w_ack) begin
                            r_tx_byte <= i_reg_rd_data;
                            r_tx_vld  <= 1'b1;
                            r_state   <= S_RD_NEXT;
                        end else if (w_timeout) begin
                            r_tx_byte <= RD_ERR_BYTE;
                            r_tx_vld  <= 1'b1;
                            r_state   <= S_RD_NEXT;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                        end
                    end
                    S_RD_NEXT: begin
                        if (i_rx_data_valid) begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= S_RD_REQ;
                        end
                    end
                    S_WR_DATA: begin
                        if (i_rx_data_valid) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= i_rx_byte;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_tx_data_valid = r_tx_vld;
    assign o_tx_byte       = (r_state == S_IDLE) ? {7'b1010000, r_err} : r_tx_byte;
    assign o_reg_addr      = r_addr;
    assign o_reg_wr_en     = r_wr_en;
    assign o_reg_wr_data   = r_wr_data;
    assign o_reg_rd_en     = (r_state == S_RD_REQ) & w_cs_act;
    assign o_busy          = (r_state != S_IDLE);
    assign o_err_timeout   = r_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized frame-level bench: a behavioural SPI-slave/register-file model
// predicts MISO bytes, strobe sequences and the error flag per frame.
module tb_spi_reg_ctrl;
    localparam int AW  = 7;
    localparam int TMO = 8;
    localparam int GAP = 20;

    logic          i_sys_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_spi_cs_b = 1'b1;
    logic          i_rx_data_valid = 1'b0;
    logic [7:0]    i_rx_byte = 8'h00;
    logic          o_tx_data_valid;
    logic [7:0]    o_tx_byte;
    logic [AW-1:0] o_reg_addr;
    logic          o_reg_wr_en;
    logic [7:0]    o_reg_wr_data;
    logic          o_reg_rd_en;
    logic [7:0]    i_reg_rd_data = 8'h00;
    logic          i_reg_rd_ack = 1'b0;
    logic          i_err_clr = 1'b0;
    logic          o_busy;
    logic          o_err_timeout;

    spi_reg_ctrl #(.ADDR_W(AW), .RD_TIMEOUT(TMO), .RD_ERR_BYTE(8'hEE)) dut (
        .i_sys_clk(i_sys_clk), .i_rst(i_rst), .i_spi_cs_b(i_spi_cs_b),
        .i_rx_data_valid(i_rx_data_valid), .i_rx_byte(i_rx_byte),
        .o_tx_data_valid(o_tx_data_valid), .o_tx_byte(o_tx_byte),
        .o_reg_addr(o_reg_addr), .o_reg_wr_en(o_reg_wr_en), .o_reg_wr_data(o_reg_wr_data),
        .o_reg_rd_en(o_reg_rd_en), .i_reg_rd_data(i_reg_rd_data), .i_reg_rd_ack(i_reg_rd_ack),
        .i_err_clr(i_err_clr), .o_busy(o_busy), .o_err_timeout(o_err_timeout)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // register file seen by the DUT, and the independent reference copy
    logic [7:0]  mem [128];
    logic [7:0]  mdl [128];
    logic        err_m = 1'b0;
    logic [7:0]  fdat [8];
    int          lat = 2;
    bit          nack = 1'b0;

    logic [7:0]  miso_q [$];
    logic [14:0] wr_q [$];
    logic [6:0]  rd_q [$];
    logic [7:0]  pend = 8'h00;
    bit          have_pend = 1'b0;
    int          tx_cnt = 0;
    int          viol = 0;

    always @(negedge i_sys_clk) begin
        if (o_tx_data_valid) begin
            pend = o_tx_byte;
            have_pend = 1'b1;
            tx_cnt++;
        end
        if (o_reg_wr_en) begin
            wr_q.push_back({o_reg_addr, o_reg_wr_data});
            mem[o_reg_addr] = o_reg_wr_data;
        end
        if (o_reg_rd_en) rd_q.push_back(o_reg_addr);
        if ((o_reg_rd_en && o_reg_wr_en) || ((o_reg_rd_en || o_reg_wr_en) && !o_busy))
            viol++;
    end

    // register-file responder: ack `lat` cycles after the read strobe
    always begin
        logic [6:0] ra;
        @(negedge i_sys_clk);
        if (o_reg_rd_en && !nack) begin
            ra = o_reg_addr;
            repeat (lat) @(negedge i_sys_clk);
            i_reg_rd_data = mem[ra];
            i_reg_rd_ack  = 1'b1;
            @(negedge i_sys_clk);
            i_reg_rd_ack  = 1'b0;
            i_reg_rd_data = 8'h00;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_sys_clk); #2;
        i_rx_byte = b;
        i_rx_data_valid = 1'b1;
        @(posedge i_sys_clk); #2;
        i_rx_data_valid = 1'b0;
        repeat (GAP) @(posedge i_sys_clk);
    endtask

    task automatic clear_err();
        @(posedge i_sys_clk); #2;
        i_err_clr = 1'b1;
        @(posedge i_sys_clk); #2;
        i_err_clr = 1'b0;
        err_m = 1'b0;
        @(posedge i_sys_clk); #1;
        chk("clr_status", {24'h0, o_tx_byte}, 32'hA0);
    endtask

    task automatic run_frame(input string name, input logic [7:0] cmd, input int n);
        logic [7:0]  exp_miso [$];
        logic [14:0] exp_wr [$];
        logic [6:0]  exp_rd [$];
        logic [6:0]  a;
        logic [6:0]  ai;
        a = cmd[6:0];
        exp_miso.push_back({7'b1010000, err_m});
        if (cmd[7]) begin
            for (int i = 0; i <= n; i++) begin
                ai = a + 7'(i);
                exp_rd.push_back(ai);
                if (i < n) exp_miso.push_back(nack ? 8'hEE : mdl[ai]);
            end
            if (nack) err_m = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                ai = a + 7'(i);
                exp_miso.push_back(8'h00);
                exp_wr.push_back({ai, fdat[i]});
                mdl[ai] = fdat[i];
            end
        end

        wr_q.delete(); rd_q.delete(); miso_q.delete();
        viol = 0;
        @(posedge i_sys_clk); #2;
        have_pend = 1'b0;
        miso_q.push_back(o_tx_byte);
        i_spi_cs_b = 1'b0;
        repeat (6) @(posedge i_sys_clk);
        send_byte(cmd);
        for (int i = 0; i < n; i++) begin
            miso_q.push_back(have_pend ? pend : 8'h00);
            have_pend = 1'b0;
            send_byte(fdat[i]);
        end
        @(posedge i_sys_clk); #2;
        i_spi_cs_b = 1'b1;
        repeat (6) @(posedge i_sys_clk);
        #1;

        for (int i = 0; i < exp_miso.size(); i++)
            chk($sformatf("%s miso%0d", name, i), {24'h0, miso_q[i]}, {24'h0, exp_miso[i]});
        chk({name, " wr_n"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            chk($sformatf("%s wr%0d", name, i), {17'h0, wr_q[i]}, {17'h0, exp_wr[i]});
        chk({name, " rd_n"}, rd_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            chk($sformatf("%s rd%0d", name, i), {25'h0, rd_q[i]}, {25'h0, exp_rd[i]});
        chk({name, " busy"}, {31'h0, o_busy}, 32'h0);
        chk({name, " err"}, {31'h0, o_err_timeout}, {31'h0, err_m});
        chk({name, " strobe_rules"}, viol, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'($urandom);
            mdl[i] = mem[i];
        end
        mem[3] = 8'h5A; mdl[3] = 8'h5A;
        mem[4] = 8'hC3; mdl[4] = 8'hC3;

        repeat (4) @(posedge i_sys_clk);
        #2 i_rst = 1'b0;
        @(posedge i_sys_clk); #1;
        chk("rst tx_byte", {24'h0, o_tx_byte}, 32'hA0);
        chk("rst busy", {31'h0, o_busy}, 32'h0);
        chk("rst err", {31'h0, o_err_timeout}, 32'h0);
        chk("rst strobes", {29'h0, o_tx_data_valid, o_reg_wr_en, o_reg_rd_en}, 32'h0);
        chk("rst addr", {25'h0, o_reg_addr}, 32'h0);
        repeat (5) @(posedge i_sys_clk);

        fdat[0] = 8'h11; fdat[1] = 8'h22;
        run_frame("wr_burst", 8'h05, 2);
        lat = 2;
        run_frame("rd_burst", 8'h83, 2);
        lat = TMO;
        run_frame("rd_maxlat", 8'h20, 2);
        nack = 1'b1;
        run_frame("timeout", 8'h90, 1);
        nack = 1'b0; lat = 1;
        run_frame("status_err", 8'h84, 1);
        clear_err();
        fdat[0] = 8'hAA; fdat[1] = 8'hBB;
        run_frame("wrap", 8'h7F, 2);
        run_frame("wrap_rd", 8'hFF, 2);

        // abort: CS released during the read wait, ack arrives afterwards
        lat = TMO;
        rd_q.delete();
        @(posedge i_sys_clk); #2;
        i_spi_cs_b = 1'b0;
        tx_cnt = 0;
        repeat (6) @(posedge i_sys_clk); #2;
        i_rx_byte = 8'h83; i_rx_data_valid = 1'b1;
        @(posedge i_sys_clk); #2;
        i_rx_data_valid = 1'b0;
        repeat (2) @(posedge i_sys_clk); #2;
        i_spi_cs_b = 1'b1;
        repeat (20) @(posedge i_sys_clk); #1;
        chk("abort tx_valid", tx_cnt, 0);
        chk("abort busy", {31'h0, o_busy}, 32'h0);
        chk("abort rd_n", rd_q.size(), 1);
        chk("abort err", {31'h0, o_err_timeout}, {31'h0, err_m});

        // reset mid-frame with CS held low: bytes after reset must be ignored
        wr_q.delete();
        @(posedge i_sys_clk); #2;
        i_spi_cs_b = 1'b0;
        repeat (6) @(posedge i_sys_clk);
        send_byte(8'h05);
        @(posedge i_sys_clk); #2;
        i_rst = 1'b1;
        @(posedge i_sys_clk); #2;
        i_rst = 1'b0;
        err_m = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        chk("rst_mid wr_n", wr_q.size(), 0);
        chk("rst_mid busy", {31'h0, o_busy}, 32'h0);
        @(posedge i_sys_clk); #2;
        i_spi_cs_b = 1'b1;
        repeat (6) @(posedge i_sys_clk);
        fdat[0] = 8'h33;
        run_frame("after_rst", 8'h06, 1);

        for (int f = 0; f < 24; f++) begin
            int n;
            logic [7:0] cmd;
            cmd  = 8'($urandom);
            n    = $urandom_range(1, 4);
            nack = ($urandom_range(0, 5) == 0);
            lat  = $urandom_range(1, TMO);
            for (int i = 0; i < 8; i++) fdat[i] = 8'($urandom);
            run_frame($sformatf("rnd%0d", f), cmd, n);
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
